conv_gather: RTL and testbench
==============================

Name: conv_gather

Overview:
- Collects per-unit results from the bank of convolution units enabled by the thermometer select mask and serializes them onto one valid/ready output stream.
- The mask enables units 0..k-1.
- Sits downstream of the conv bank.
- Also decodes the mask back to a unit count and flags malformed masks.

Parameters:
- N_CONV, 13, number of convolution units (mask width).
- DATAWIDTH, 8, signed result width per unit.
- BITWIDTH_W_ROWS, 4, width of count/index fields (must hold N_CONV).

Ports:
- CONV_GATHER_CLOCK_50  in  1  system clock, rising edge.
- CONV_GATHER_RESET_InLow  in  1  asynchronous, active-low reset.
- CONV_GATHER_Sel  in  N_CONV  thermometer enable mask, bit i = unit i.
- CONV_GATHER_Start  in  1  latch Sel and open a collection window.
- CONV_GATHER_Valid  in  N_CONV  per-unit result strobe, one cycle.
- CONV_GATHER_Data  in  N_CONV*DATAWIDTH  unit i result in slice [i*DATAWIDTH +: DATAWIDTH].
- CONV_GATHER_Out_Data  out  DATAWIDTH  serialized result.
- CONV_GATHER_Out_Idx  out  BITWIDTH_W_ROWS  source unit index of Out_Data.
- CONV_GATHER_Out_Valid  out  1  output valid.
- CONV_GATHER_Out_Ready  in  1  downstream ready.
- CONV_GATHER_Count  out  BITWIDTH_W_ROWS  decoded count of latched mask (0 if invalid).
- CONV_GATHER_Busy  out  1  high in COLLECT or DRAIN.
- CONV_GATHER_Done  out  1  one-cycle pulse after last result accepted.
- CONV_GATHER_Error  out  1  sticky: invalid mask or overrun.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0; mask, pending, capture registers and pointer cleared.
- States: IDLE, COLLECT, DRAIN.
- IDLE:
  - Start with a valid mask: latch mask, set Count = number of ones, clear Error and pending, go to COLLECT next cycle.
  - A valid mask is a non-zero thermometer code, i.e. ones contiguous from bit 0.
  - Start with an invalid mask: stay IDLE, set Error, Count = 0.
- COLLECT: on each edge, for every i with Valid[i] & mask[i]:
  - Capture the Data slice into cap[i] and set pending[i].
  - Valid[i] with mask[i] = 0 is ignored.
  - Valid[i] with pending[i] already set is an overrun: set Error, keep the first captured value.
  - When pending == mask after an edge, go to DRAIN on the next edge with ptr = 0. Simultaneous final strobes count in the same cycle.
- DRAIN:
  - Out_Valid = 1, Out_Data = cap[ptr], Out_Idx = ptr.
  - Out_Valid & Out_Ready: ptr increments.
  - Accepting ptr = Count-1: go to IDLE, Done pulses for one cycle, Out_Valid drops the same edge.
  - Out_Data and Out_Idx are held stable while Out_Valid & !Out_Ready.
- Start while Busy is ignored. The latched mask is unchanged and Error is not set.
- Valid strobes outside COLLECT are ignored.
- Latency: the first Out_Valid appears 1 cycle after the edge that captured the last pending result. Throughput is 1 result per cycle with Ready held high.
- Reset mid-operation: immediate return to IDLE and all outputs to 0. Partial captures are discarded.
- Busy = (state != IDLE). Count holds its value until the next accepted Start.

Optional Feature:
- Macro: CONV_GATHER_RELU_EN.
- Defined: Out_Data = 0 when cap[ptr] is negative (two's complement MSB set), else cap[ptr]. Applied combinationally on the output path, no added latency.
- Undefined: Out_Data = cap[ptr] unmodified.

Decomposition:
- Shared package: state encoding localparams (IDLE/COLLECT/DRAIN), N_CONV default, DATAWIDTH default.
- One natural sub-module: conv_sel_decoder. It is combinational: N_CONV mask in, outputs count and is_valid (non-zero thermometer check). It is the inverse of the row-count-to-mask select logic.

Test Plan:
- Start with Sel=13'h001F, strobe Valid bits 0..4 in separate cycles with data 10..14, Ready=1 -> Count=5, outputs idx 0..4 data 10..14 on consecutive cycles, Done once, Error=0.
- Sel=13'h0007, all three Valid in one cycle, Ready toggled 1/0 -> each result held while Ready=0, exactly 3 transfers, Done after third.
- Start with Sel=13'h0005 (non-thermometer) and again with Sel=0 -> stays IDLE, Busy=0, Count=0, Error=1. Next valid Start (13'h0001) clears Error.
- Sel=13'h0003, Valid[0] twice (data 7 then 9), then Valid[1], plus Valid[5] -> Error=1, output idx0=7, idx1 data correct, unit 5 ignored.
- Mid-COLLECT, assert RESET_InLow=0 for one cycle -> Busy=0, Out_Valid=0, Count=0 immediately. Subsequent Start works normally.
- With CONV_GATHER_RELU_EN defined, Sel=13'h0003, data -3 and 4 -> outputs 0 and 4. Without the macro -> 8'hFD and 4.

Source files
------------

// File: rtl/conv_gather_pkg.sv
// Shared types and default sizes for the conv_gather result collector.
package conv_gather_pkg;

  localparam int unsigned N_CONV_DEF          = 13;
  localparam int unsigned DATAWIDTH_DEF       = 8;
  localparam int unsigned BITWIDTH_W_ROWS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } gather_state_e;

endpackage

// File: rtl/conv_sel_decoder.sv
// Thermometer select mask -> unit count, plus a well-formedness flag.
module conv_sel_decoder
  import conv_gather_pkg::*;
#(
  parameter int unsigned N_CONV          = N_CONV_DEF,
  parameter int unsigned BITWIDTH_W_ROWS = BITWIDTH_W_ROWS_DEF
) (
  input  logic [N_CONV-1:0]          sel,
  output logic [BITWIDTH_W_ROWS-1:0] count,
  output logic                       is_valid
);

  localparam logic [N_CONV-1:0] ONE = N_CONV'(1);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < N_CONV; i++) begin
      count = count + BITWIDTH_W_ROWS'(sel[i]);
    end
    // ones contiguous from bit 0 <=> adding one clears every set bit
    is_valid = (sel != '0) && ((sel & (sel + ONE)) == '0);
  end

endmodule

// File: rtl/conv_gather.sv
// Gathers masked conv-unit results and serializes them on a valid/ready stream.
// Optional macro CONV_GATHER_RELU_EN clamps negative results to zero on output.
module conv_gather
  import conv_gather_pkg::*;
#(
  parameter int unsigned N_CONV          = N_CONV_DEF,
  parameter int unsigned DATAWIDTH       = DATAWIDTH_DEF,
  parameter int unsigned BITWIDTH_W_ROWS = BITWIDTH_W_ROWS_DEF
) (
  input  logic                          CONV_GATHER_CLOCK_50,
  input  logic                          CONV_GATHER_RESET_InLow,
  input  logic [N_CONV-1:0]             CONV_GATHER_Sel,
  input  logic                          CONV_GATHER_Start,
  input  logic [N_CONV-1:0]             CONV_GATHER_Valid,
  input  logic [N_CONV*DATAWIDTH-1:0]   CONV_GATHER_Data,
  output logic [DATAWIDTH-1:0]          CONV_GATHER_Out_Data,
  output logic [BITWIDTH_W_ROWS-1:0]    CONV_GATHER_Out_Idx,
  output logic                          CONV_GATHER_Out_Valid,
  input  logic                          CONV_GATHER_Out_Ready,
  output logic [BITWIDTH_W_ROWS-1:0]    CONV_GATHER_Count,
  output logic                          CONV_GATHER_Busy,
  output logic                          CONV_GATHER_Done,
  output logic                          CONV_GATHER_Error
);

  gather_state_e               state_q, state_d;
  logic [N_CONV-1:0]           mask_q, mask_d;
  logic [N_CONV-1:0]           pending_q, pending_d;
  logic [DATAWIDTH-1:0]        cap_q [N_CONV];
  logic [DATAWIDTH-1:0]        cap_d [N_CONV];
  logic [BITWIDTH_W_ROWS-1:0]  ptr_q, ptr_d;
  logic [BITWIDTH_W_ROWS-1:0]  count_q, count_d;
  logic                        error_q, error_d;
  logic                        done_q, done_d;

  logic [BITWIDTH_W_ROWS-1:0]  dec_count;
  logic                        dec_valid;
  logic [DATAWIDTH-1:0]        head_data;

  conv_sel_decoder #(
    .N_CONV          (N_CONV),
    .BITWIDTH_W_ROWS (BITWIDTH_W_ROWS)
  ) u_sel_decoder (
    .sel      (CONV_GATHER_Sel),
    .count    (dec_count),
    .is_valid (dec_valid)
  );

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    pending_d = pending_q;
    cap_d     = cap_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    error_d   = error_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CONV_GATHER_Start) begin
          if (dec_valid) begin
            mask_d    = CONV_GATHER_Sel;
            count_d   = dec_count;
            error_d   = 1'b0;
            pending_d = '0;
            state_d   = ST_COLLECT;
          end else begin
            error_d = 1'b1;
            count_d = '0;
          end
        end
      end

      ST_COLLECT: begin
        // completion is judged on the registered pending set, so DRAIN
        // begins one edge after the final capture
        if (pending_q == mask_q) begin
          state_d = ST_DRAIN;
          ptr_d   = '0;
        end
        for (int unsigned i = 0; i < N_CONV; i++) begin
          if (CONV_GATHER_Valid[i] && mask_q[i]) begin
            if (pending_q[i]) begin
              error_d = 1'b1;
            end else begin
              cap_d[i]     = CONV_GATHER_Data[i*DATAWIDTH +: DATAWIDTH];
              pending_d[i] = 1'b1;
            end
          end
        end
      end

      ST_DRAIN: begin
        if (CONV_GATHER_Out_Ready) begin
          if (ptr_q == count_q - BITWIDTH_W_ROWS'(1)) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + BITWIDTH_W_ROWS'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CONV_GATHER_CLOCK_50 or negedge CONV_GATHER_RESET_InLow) begin
    if (!CONV_GATHER_RESET_InLow) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      pending_q <= '0;
      ptr_q     <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < N_CONV; i++) begin
        cap_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      error_q   <= error_d;
      done_q    <= done_d;
      cap_q     <= cap_d;
    end
  end

  always_comb begin
    head_data = cap_q[ptr_q];
`ifdef CONV_GATHER_RELU_EN
    if (head_data[DATAWIDTH-1]) begin
      head_data = '0;
    end
`endif
  end

  assign CONV_GATHER_Out_Valid = (state_q == ST_DRAIN);
  assign CONV_GATHER_Out_Data  = (state_q == ST_DRAIN) ? head_data : '0;
  assign CONV_GATHER_Out_Idx   = (state_q == ST_DRAIN) ? ptr_q : '0;
  assign CONV_GATHER_Busy      = (state_q != ST_IDLE);
  assign CONV_GATHER_Count     = count_q;
  assign CONV_GATHER_Done      = done_q;
  assign CONV_GATHER_Error     = error_q;

endmodule

// File: tb/tb_conv_gather.sv
// Directed bench for conv_gather with a queue-based reference model.
module tb_conv_gather;

  localparam int N  = 13;
  localparam int DW = 8;
  localparam int BW = 4;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      sel   = '0;
  logic              start = 1'b0;
  logic [N-1:0]      valid = '0;
  logic [N*DW-1:0]   data  = '0;
  logic              ready = 1'b0;

  logic [DW-1:0]     out_data;
  logic [BW-1:0]     out_idx;
  logic              out_valid;
  logic [BW-1:0]     count;
  logic              busy;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  conv_gather #(
    .N_CONV          (N),
    .DATAWIDTH       (DW),
    .BITWIDTH_W_ROWS (BW)
  ) dut (
    .CONV_GATHER_CLOCK_50    (clk),
    .CONV_GATHER_RESET_InLow (rst_n),
    .CONV_GATHER_Sel         (sel),
    .CONV_GATHER_Start       (start),
    .CONV_GATHER_Valid       (valid),
    .CONV_GATHER_Data        (data),
    .CONV_GATHER_Out_Data    (out_data),
    .CONV_GATHER_Out_Idx     (out_idx),
    .CONV_GATHER_Out_Valid   (out_valid),
    .CONV_GATHER_Out_Ready   (ready),
    .CONV_GATHER_Count       (count),
    .CONV_GATHER_Busy        (busy),
    .CONV_GATHER_Done        (done),
    .CONV_GATHER_Error       (error)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int n_done  = 0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, got, got, exp, exp, cyc);
  endtask

  function automatic int exp_data(input int d);
`ifdef CONV_GATHER_RELU_EN
    if (d >= 128) return 0;
`endif
    return d;
  endfunction

  // Reference model: a list of pending transfers, built once all masked units reported
  typedef struct { int idx; int data; } xfer_t;
  xfer_t m_q[$];
  bit    m_collect;
  int    m_mask, m_got, m_count;
  bit    m_error, m_done;
  int    m_val [N];

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_collect = 0; m_mask = 0; m_got = 0; m_count = 0;
      m_error = 0; m_done = 0;
      for (int i = 0; i < N; i++) m_val[i] = 0;
    end else begin
      bit complete;
      m_done = 0;
      if (m_q.size() > 0) begin
        if (ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_done = 1;
        end
      end else if (m_collect) begin
        complete = (m_got == m_mask);
        for (int i = 0; i < N; i++) begin
          if (valid[i] && ((m_mask >> i) & 1) == 1) begin
            if (((m_got >> i) & 1) == 1) m_error = 1;
            else begin
              m_val[i] = int'(data[i*DW +: DW]);
              m_got    = m_got | (1 << i);
            end
          end
        end
        if (complete) begin
          for (int k = 0; k < m_count; k++) m_q.push_back('{k, m_val[k]});
          m_collect = 0;
        end
      end else if (start) begin
        int m, k;
        m = int'(sel);
        k = $countones(sel);
        if (k > 0 && m == (1 << k) - 1) begin
          m_mask = m; m_count = k; m_error = 0; m_got = 0; m_collect = 1;
        end else begin
          m_error = 1; m_count = 0;
        end
      end
    end
  end

  typedef struct { int idx; int data; int c; } log_t;
  log_t lg[$];

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy",      int'(busy),      int'(m_collect || m_q.size() > 0));
      check("out_valid", int'(out_valid), int'(m_q.size() > 0));
      check("count",     int'(count),     m_count);
      check("error",     int'(error),     int'(m_error));
      check("done",      int'(done),      int'(m_done));
      if (m_q.size() > 0) begin
        check("out_data", int'(out_data), exp_data(m_q[0].data));
        check("out_idx",  int'(out_idx),  m_q[0].idx);
      end
      if (out_valid && ready) lg.push_back('{int'(out_idx), int'(out_data), cyc});
      if (done) n_done++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [N-1:0] m);
    sel = m; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_d(input int unit, input int val);
    logic [DW-1:0] v;
    v = DW'(val);
    data[unit*DW +: DW] = v;
  endtask

  task automatic strobe(input logic [N-1:0] v);
    valid = v;
    tick();
    valid = '0;
  endtask

  task automatic wait_idle(input bit toggle);
    int c;
    c = 0;
    while (busy && c < 200) begin
      if (toggle) ready = ~ready;
      tick();
      c++;
    end
    if (busy) check("idle_timeout", 1, 0);
    ready = 1'b1;
  endtask

  task automatic clear_log();
    lg.delete();
    n_done = 0;
  endtask

  initial begin
    int c_last;
    #1;
    check("rst_busy",      int'(busy),      0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_count",     int'(count),     0);
    check("rst_error",     int'(error),     0);
    check("rst_done",      int'(done),      0);
    check("rst_out_data",  int'(out_data),  0);
    check("rst_out_idx",   int'(out_idx),   0);
    tick(); tick();
    rst_n = 1'b1;
    ready = 1'b1;
    tick();

    // five units strobed one per cycle, ready held high
    clear_log();
    do_start(13'h001F);
    check("t1_count", int'(count), 5);
    for (int i = 0; i < 5; i++) begin
      set_d(i, 10 + i);
      strobe(N'(1) << i);
    end
    c_last = cyc;
    wait_idle(1'b0);
    check("t1_n_xfer", lg.size(), 5);
    if (lg.size() == 5) begin
      check("t1_latency", lg[0].c, c_last + 1);
      for (int k = 0; k < 5; k++) begin
        check("t1_idx",    lg[k].idx, k);
        check("t1_data",   lg[k].data, 10 + k);
        check("t1_consec", lg[k].c, lg[0].c + k);
      end
    end
    check("t1_done_cnt", n_done, 1);
    check("t1_error",    int'(error), 0);

    // three simultaneous strobes, ready toggling
    clear_log();
    do_start(13'h0007);
    set_d(0, 8'h21); set_d(1, 8'h22); set_d(2, 8'h23);
    strobe(13'h0007);
    ready = 1'b0;
    wait_idle(1'b1);
    check("t2_n_xfer", lg.size(), 3);
    if (lg.size() == 3) begin
      check("t2_d0", lg[0].data, 8'h21);
      check("t2_d1", lg[1].data, 8'h22);
      check("t2_d2", lg[2].data, 8'h23);
    end
    check("t2_done_cnt", n_done, 1);

    // malformed masks
    do_start(13'h0005);
    check("t3a_busy",  int'(busy),  0);
    check("t3a_count", int'(count), 0);
    check("t3a_error", int'(error), 1);
    do_start(13'h0000);
    check("t3b_busy",  int'(busy),  0);
    check("t3b_count", int'(count), 0);
    check("t3b_error", int'(error), 1);
    clear_log();
    do_start(13'h0001);
    check("t3c_error", int'(error), 0);
    check("t3c_count", int'(count), 1);
    check("t3c_busy",  int'(busy),  1);
    set_d(0, 8'h42);
    strobe(13'h0001);
    wait_idle(1'b0);
    check("t3c_n_xfer", lg.size(), 1);
    if (lg.size() == 1) check("t3c_data", lg[0].data, 8'h42);

    // overrun on unit 0, unmasked unit 5 ignored
    clear_log();
    do_start(13'h0003);
    set_d(0, 7);    strobe(13'h0001);
    set_d(0, 9);    strobe(13'h0001);
    set_d(1, 8'h55); set_d(5, 8'h66); strobe(13'h0022);
    wait_idle(1'b0);
    check("t4_error",  int'(error), 1);
    check("t4_n_xfer", lg.size(), 2);
    if (lg.size() == 2) begin
      check("t4_d0", lg[0].data, 7);
      check("t4_d1", lg[1].data, 8'h55);
      check("t4_i1", lg[1].idx, 1);
    end

    // reset in the middle of collection
    do_start(13'h0003);
    set_d(0, 1); strobe(13'h0001);
    rst_n = 1'b0;
    #1;
    check("t5_busy",      int'(busy),      0);
    check("t5_out_valid", int'(out_valid), 0);
    check("t5_count",     int'(count),     0);
    tick();
    rst_n = 1'b1;
    tick();

    // negative result through the output path
    clear_log();
    do_start(13'h0003);
    check("t6_count", int'(count), 2);
    set_d(0, 8'hFD); set_d(1, 4);
    strobe(13'h0003);
    wait_idle(1'b0);
    check("t6_n_xfer", lg.size(), 2);
    if (lg.size() == 2) begin
`ifdef CONV_GATHER_RELU_EN
      check("t6_d0", lg[0].data, 0);
`else
      check("t6_d0", lg[0].data, 8'hFD);
`endif
      check("t6_d1", lg[1].data, 4);
    end

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
